// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: exception causes, CP0 status bits, sequencer states
package cpu_pkg;

    localparam logic [3:0] CAUSE_NONE    = 4'd0;
    localparam logic [3:0] CAUSE_SYSCALL = 4'd8;
    localparam logic [3:0] CAUSE_BREAK   = 4'd9;
    localparam logic [3:0] CAUSE_TEQ     = 4'd13;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_SYSCALL = 1;
    localparam int STATUS_BREAK   = 2;
    localparam int STATUS_TEQ     = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_REDIRECT
    } exc_state_t;

endpackage

// File: rtl/exc_prio.sv
// rtl/exc_prio.sv - combinational exception priority and qualification encoder
module exc_prio
    import cpu_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_syscall,
    input  logic       ex_break,
    input  logic       ex_teq,
    input  logic       ex_eret,
    input  logic       ex_teq_eq,
    input  logic [3:0] status,
    input  logic       in_handler,
    output logic       hit,
    output logic       is_eret,
    output logic [3:0] cause
);

    logic trap_ok;
    assign trap_ok = ex_valid && status[STATUS_IE] && !in_handler;

    // Priority is decided on the raw opcode flags: a disabled higher-priority
    // flag still masks every lower-priority one.
    always_comb begin
        hit     = 1'b0;
        is_eret = 1'b0;
        cause   = CAUSE_NONE;
        if (ex_syscall) begin
            if (trap_ok && status[STATUS_SYSCALL]) begin
                hit   = 1'b1;
                cause = CAUSE_SYSCALL;
            end
        end else if (ex_break) begin
            if (trap_ok && status[STATUS_BREAK]) begin
                hit   = 1'b1;
                cause = CAUSE_BREAK;
            end
        end else if (ex_teq) begin
            if (trap_ok && status[STATUS_TEQ] && ex_teq_eq) begin
                hit   = 1'b1;
                cause = CAUSE_TEQ;
            end
        end else if (ex_eret) begin
            if (ex_valid && in_handler) begin
                hit     = 1'b1;
                is_eret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_unit.sv
// rtl/exc_unit.sv - exception sequencer: qualify EX traps/eret, drive CP0, drain and redirect the pipeline
module exc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_syscall,
    input  logic        ex_break,
    input  logic        ex_teq,
    input  logic        ex_eret,
    input  logic        ex_teq_eq,
    input  logic [31:0] ex_pc,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [3:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        flush,
    output logic        stall_fetch,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        in_handler
);

    exc_state_t state;
    logic [2:0] drain_cnt;
    logic       hit;
    logic       is_eret;
    logic [3:0] cause;
    logic       unused_status;

    assign unused_status = ^cp0_status[31:4];

    exc_prio u_prio (
        .ex_valid   (ex_valid),
        .ex_syscall (ex_syscall),
        .ex_break   (ex_break),
        .ex_teq     (ex_teq),
        .ex_eret    (ex_eret),
        .ex_teq_eq  (ex_teq_eq),
        .status     (cp0_status[3:0]),
        .in_handler (in_handler),
        .hit        (hit),
        .is_eret    (is_eret),
        .cause      (cause)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            drain_cnt      <= 3'd0;
            cp0_exception  <= 1'b0;
            cp0_eret       <= 1'b0;
            cp0_cause      <= CAUSE_NONE;
            cp0_pc         <= 32'd0;
            flush          <= 1'b0;
            stall_fetch    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            in_handler     <= 1'b0;
        end else begin
            // CP0 strobes and their payload live for exactly one cycle
            cp0_exception <= 1'b0;
            cp0_eret      <= 1'b0;
            cp0_cause     <= CAUSE_NONE;
            cp0_pc        <= 32'd0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state       <= ST_DRAIN;
                        drain_cnt   <= 3'(DRAIN_CYCLES - 1);
                        flush       <= 1'b1;
                        stall_fetch <= 1'b1;
                        if (is_eret) begin
                            cp0_eret    <= 1'b1;
                            redirect_pc <= cp0_epc;
                            in_handler  <= 1'b0;
                        end else begin
                            cp0_exception <= 1'b1;
                            cp0_cause     <= cause;
                            cp0_pc        <= ex_pc + 32'd4;
                            redirect_pc   <= HANDLER_ADDR;
                            in_handler    <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state          <= ST_REDIRECT;
                        redirect_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                ST_REDIRECT: begin
                    state          <= ST_IDLE;
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                    stall_fetch    <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_unit.sv
// tb/tb_exc_unit.sv - table-driven scoreboard bench for exc_unit
module tb_exc_unit;

    localparam int DRAIN = 2;
    localparam logic [31:0] HANDLER = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_syscall = 1'b0, ex_break = 1'b0, ex_teq = 1'b0;
    logic        ex_eret = 1'b0, ex_teq_eq = 1'b0;
    logic [31:0] ex_pc = 32'd0, cp0_status = 32'd0, cp0_epc = 32'd0;
    logic        cp0_exception, cp0_eret, flush, stall_fetch, redirect_valid, in_handler;
    logic [3:0]  cp0_cause;
    logic [31:0] cp0_pc, redirect_pc;

    exc_unit #(.HANDLER_ADDR(HANDLER), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_syscall(ex_syscall),
        .ex_break(ex_break), .ex_teq(ex_teq), .ex_eret(ex_eret), .ex_teq_eq(ex_teq_eq),
        .ex_pc(ex_pc), .cp0_status(cp0_status), .cp0_epc(cp0_epc),
        .cp0_exception(cp0_exception), .cp0_eret(cp0_eret), .cp0_cause(cp0_cause),
        .cp0_pc(cp0_pc), .flush(flush), .stall_fetch(stall_fetch),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, sys, brk, teq, eret, teq_eq;
        logic [31:0] status, pc, epc;
        logic        hit, is_eret;
        logic [3:0]  cause;
        logic [31:0] cpc, target;
        logic        ih;
    } vec_t;

    typedef struct {
        logic        is_eret;
        logic [3:0]  cause;
        logic [31:0] cpc;
    } pulse_t;

    pulse_t      pulse_q[$];
    logic [31:0] redir_q[$];
    int          passed = 0;
    int          total = 0;
    vec_t        vt[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic valid, sys, brk, teq, eret, teq_eq,
                                input logic [31:0] status, pc, epc,
                                input logic hit, is_eret, input logic [3:0] cause,
                                input logic [31:0] cpc, target, input logic ih);
        vec_t v;
        v.valid = valid; v.sys = sys; v.brk = brk; v.teq = teq; v.eret = eret;
        v.teq_eq = teq_eq; v.status = status; v.pc = pc; v.epc = epc;
        v.hit = hit; v.is_eret = is_eret; v.cause = cause; v.cpc = cpc;
        v.target = target; v.ih = ih;
        return v;
    endfunction

    // Scoreboard: every CP0 strobe and every redirect must match a queued expectation.
    always @(negedge clk) begin
        pulse_t p;
        if (rst_n) begin
            if (cp0_exception || cp0_eret) begin
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    p = pulse_q.pop_front();
                    chk("pulse_kind", {31'd0, cp0_eret}, {31'd0, p.is_eret});
                    chk("pulse_cause", {28'd0, cp0_cause}, {28'd0, p.cause});
                    if (!p.is_eret) chk("pulse_cpc", cp0_pc, p.cpc);
                    chk("pulse_flush", {31'd0, flush & stall_fetch}, 32'd1);
                end
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) chk("unexpected_redirect", 32'd1, 32'd0);
                else chk("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end
    end

    task automatic drive(input vec_t v, input bit push);
        pulse_t p;
        ex_valid = v.valid; ex_syscall = v.sys; ex_break = v.brk; ex_teq = v.teq;
        ex_eret = v.eret; ex_teq_eq = v.teq_eq; cp0_status = v.status;
        ex_pc = v.pc; cp0_epc = v.epc;
        if (push && v.hit) begin
            p.is_eret = v.is_eret; p.cause = v.cause; p.cpc = v.cpc;
            pulse_q.push_back(p);
            redir_q.push_back(v.target);
        end
    endtask

    task automatic clear_after_edge(input vec_t v);
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_syscall = 1'b0; ex_break = 1'b0; ex_teq = 1'b0;
        ex_eret = 1'b0; ex_teq_eq = 1'b0;
        cp0_epc = ~v.epc;
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v, 1'b1);
        clear_after_edge(v);
        repeat (DRAIN + 4) @(negedge clk);
        chk({name, "_in_handler"}, {31'd0, in_handler}, {31'd0, v.ih});
        chk({name, "_idle_flush"}, {31'd0, flush}, 32'd0);
    endtask

    initial begin
        vec_t  s;
        logic  seen;
        logic [3:0] exp_flush = 4'b0111, exp_exc = 4'b0001, exp_rv = 4'b0100;

        vt[0]  = mk(1,0,0,0,1,0, 32'h0F, 32'h0040_0030, 32'h0040_0020, 1,1, 4'd0,  32'd0,         32'h0040_0020, 0);
        vt[1]  = mk(1,0,0,0,1,0, 32'h0F, 32'h0040_0034, 32'h0040_0020, 0,0, 4'd0,  32'd0,         32'd0,         0);
        vt[2]  = mk(1,0,1,0,0,0, 32'h0B, 32'h0040_0040, 32'd0,         0,0, 4'd0,  32'd0,         32'd0,         0);
        vt[3]  = mk(1,0,0,1,0,0, 32'h0F, 32'h0040_0100, 32'd0,         0,0, 4'd0,  32'd0,         32'd0,         0);
        vt[4]  = mk(1,0,0,1,0,1, 32'h0F, 32'h0040_0100, 32'd0,         1,0, 4'd13, 32'h0040_0104, HANDLER,       1);
        vt[5]  = mk(1,1,0,0,0,0, 32'h0F, 32'h0040_0200, 32'd0,         0,0, 4'd0,  32'd0,         32'd0,         1);
        vt[6]  = mk(1,0,0,0,1,0, 32'h0F, 32'h0040_0204, 32'h1234_5678, 1,1, 4'd0,  32'd0,         32'h1234_5678, 0);
        vt[7]  = mk(1,1,0,0,1,0, 32'h03, 32'hFFFF_FFFC, 32'h0BAD_0000, 1,0, 4'd8,  32'd0,         HANDLER,       1);
        vt[8]  = mk(1,0,0,0,1,0, 32'h03, 32'h0040_0300, 32'h0040_0028, 1,1, 4'd0,  32'd0,         32'h0040_0028, 0);
        vt[9]  = mk(1,1,0,0,0,0, 32'h0E, 32'h0040_0400, 32'd0,         0,0, 4'd0,  32'd0,         32'd0,         0);
        vt[10] = mk(1,0,1,0,0,0, 32'h05, 32'h0040_0040, 32'd0,         1,0, 4'd9,  32'h0040_0044, HANDLER,       1);
        vt[11] = mk(0,0,0,0,1,0, 32'h05, 32'h0040_0500, 32'h0040_0044, 0,0, 4'd0,  32'd0,         32'd0,         1);
        vt[12] = mk(1,0,0,0,1,0, 32'h05, 32'h0040_0504, 32'h0040_0044, 1,1, 4'd0,  32'd0,         32'h0040_0044, 0);

        // Reset values
        #12;
        chk("rst_exception", {31'd0, cp0_exception}, 32'd0);
        chk("rst_eret", {31'd0, cp0_eret}, 32'd0);
        chk("rst_cause", {28'd0, cp0_cause}, 32'd0);
        chk("rst_cpc", cp0_pc, 32'd0);
        chk("rst_flush", {31'd0, flush | stall_fetch | redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_in_handler", {31'd0, in_handler}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Hand sequence: syscall with cycle-by-cycle timing of strobes, flush and redirect
        s = mk(1,1,0,0,0,0, 32'h0F, 32'h0040_0020, 32'd0, 1,0, 4'd8, 32'h0040_0024, HANDLER, 1);
        drive(s, 1'b1);
        clear_after_edge(s);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("sys_exc_c%0d", k + 1), {31'd0, cp0_exception}, {31'd0, exp_exc[k]});
            chk($sformatf("sys_flush_c%0d", k + 1), {31'd0, flush}, {31'd0, exp_flush[k]});
            chk($sformatf("sys_stall_c%0d", k + 1), {31'd0, stall_fetch}, {31'd0, exp_flush[k]});
            chk($sformatf("sys_redir_c%0d", k + 1), {31'd0, redirect_valid}, {31'd0, exp_rv[k]});
        end
        chk("sys_redirect_pc_hold", redirect_pc, HANDLER);
        chk("sys_in_handler", {31'd0, in_handler}, 32'd1);

        for (int i = 0; i < 13; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Reset asserted during DRAIN: immediate clear, no redirect afterwards
        @(negedge clk);
        s = mk(1,1,0,0,0,0, 32'h0F, 32'h0040_0600, 32'd0, 1,0, 4'd8, 32'h0040_0604, HANDLER, 1);
        drive(s, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_syscall = 1'b0;
        #1;
        chk("midrst_exception", {31'd0, cp0_exception}, 32'd0);
        chk("midrst_flush", {31'd0, flush | stall_fetch}, 32'd0);
        chk("midrst_in_handler", {31'd0, in_handler}, 32'd0);
        chk("midrst_cause", {28'd0, cp0_cause}, 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | redirect_valid;
        end
        chk("midrst_no_redirect", {31'd0, seen}, 32'd0);

        apply(mk(1,1,0,0,0,0, 32'h0F, 32'h0040_0700, 32'd0, 1,0, 4'd8, 32'h0040_0704, HANDLER, 1), "post_rst_sys");
        apply(mk(1,0,0,0,1,0, 32'h0F, 32'h0040_0800, 32'h0040_0700, 1,1, 4'd0, 32'd0, 32'h0040_0700, 0), "post_rst_eret");

        chk("pulse_queue_drained", pulse_q.size(), 32'd0);
        chk("redirect_queue_drained", redir_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
